conv_encoder_punct_param: RTL and testbench

//  Parametrised rate-1/2 convolutional encoder with programmable puncturing (1/2, 2/3, 3/4, 5/6),

---
 rtl/conv_enc_pkg.sv | 33 +++
 rtl/conv_enc_puncturer.sv | 40 ++++
 rtl/conv_encoder_punct_param.sv | 154 +++++++++++++++
 tb/tb_conv_encoder_punct_param.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_enc_pkg.sv
// Shared types and constants for the punctured convolutional encoder:
// rate enumeration, rate-code decode, and the per-rate puncture period and pattern ROM.
package conv_enc_pkg;

    typedef enum logic [1:0] {R12, R23, R34, R56} rate_e;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TAIL} frame_state_e;

    localparam int PHASE_W = 3;

    // Number of symbols in one puncture period, indexed by rate_e.
    localparam logic [PHASE_W-1:0] PAT_PERIOD [4] = '{3'd1, 3'd2, 3'd3, 3'd5};

    // Keep masks {A,B} per phase; element [p] of each entry is the mask for phase p.
    localparam logic [4:0][1:0] PAT_ROM [4] = '{
        {2'b11, 2'b11, 2'b11, 2'b11, 2'b11},
        {2'b11, 2'b11, 2'b11, 2'b10, 2'b11},
        {2'b11, 2'b11, 2'b01, 2'b10, 2'b11},
        {2'b01, 2'b10, 2'b01, 2'b10, 2'b11}
    };

    function automatic rate_e decode_rate(input logic [3:0] code);
        rate_e r;
        case (code)
            4'b0001:                            r = R23;
            4'b1111, 4'b0111, 4'b1011, 4'b0011: r = R34;
            4'b0010:                            r = R56;
            default:                            r = R12;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/conv_enc_puncturer.sv
// Puncture phase counter and keep-mask lookup. The phase is frozen during the
// unpunctured preamble and returns to zero on the frame-end clear.
module conv_enc_puncturer
    import conv_enc_pkg::*;
(
    input  logic       Clk,
    input  logic       reset,
    input  logic [1:0] rate_i,
    input  logic       adv_i,
    input  logic       clr_i,
    input  logic       preamble_i,
    output logic [1:0] keep_o
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] period;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        period  = PAT_PERIOD[rate_i];
        phase_d = phase_q;
        if (clr_i) begin
            phase_d = '0;
        end else if (adv_i && !preamble_i) begin
            phase_d = (phase_q == period - 3'd1) ? '0 : phase_q + 3'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign keep_o = preamble_i ? 2'b11 : PAT_ROM[rate_i][phase_q];

endmodule

// File: rtl/conv_encoder_punct_param.sv
// Rate-1/2 convolutional encoder with per-frame latched puncturing and valid/ready
// handshakes. Define TAIL_FLUSH_EN to append K-1 zero-input tail symbols per frame.
module conv_encoder_punct_param
    import conv_enc_pkg::*;
#(
    parameter int             K            = 7,
    parameter logic [K-1:0]   G_A          = 7'b1101101,
    parameter logic [K-1:0]   G_B          = 7'b1001111,
    parameter int             PREAMBLE_LEN = 24
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic [3:0] rate,
    output logic [1:0] out_ab,
    output logic [1:0] out_valid,
    output logic       out_last,
    input  logic       out_ready
);

    localparam logic [7:0] PRE       = 8'(PREAMBLE_LEN);
    localparam logic [3:0] TAIL_LAST = 4'(K - 2);

    frame_state_e state_q, state_d;
    rate_e        rate_q, rate_d, eff_rate;
    logic [K-1:1] sr_q, sr_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [3:0]   tail_q, tail_d;
    logic [1:0]   ab_q, ab_d, vld_q, vld_d;
    logic         last_q, last_d;
    logic         rdy_en_q;

    logic         slot_free, accept, tail_adv, tail_done, advance;
    logic         din, preamble, frame_end, last_sym;
    logic [K-1:0] window;
    logic [1:0]   keep;

    assign slot_free = (vld_q == 2'b00) || out_ready;
    assign in_ready  = rdy_en_q && slot_free && (state_q != ST_TAIL);
    assign accept    = in_valid && in_ready;
`ifdef TAIL_FLUSH_EN
    assign tail_adv  = (state_q == ST_TAIL) && slot_free;
`else
    assign tail_adv  = 1'b0;
`endif
    assign tail_done = tail_adv && (tail_q == TAIL_LAST);
    assign advance   = accept || tail_adv;
    assign din       = accept ? in_bit : 1'b0;
    assign window    = {sr_q, din};
    // The first bit of a frame must already be punctured with the rate it latches.
    assign eff_rate  = (state_q == ST_IDLE) ? decode_rate(rate) : rate_q;
    assign preamble  = cnt_q < PRE;
`ifdef TAIL_FLUSH_EN
    assign frame_end = tail_done;
`else
    assign frame_end = accept && in_last;
`endif
    assign last_sym  = frame_end;

    conv_enc_puncturer u_punct (
        .Clk        (Clk),
        .reset      (reset),
        .rate_i     (eff_rate),
        .adv_i      (advance),
        .clr_i      (frame_end),
        .preamble_i (preamble),
        .keep_o     (keep)
    );

    always_comb begin
        state_d = state_q;
        rate_d  = rate_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        tail_d  = tail_q;
        ab_d    = ab_q;
        vld_d   = vld_q;
        last_d  = last_q;

        if (advance) begin
            sr_d   = window[K-2:0];
            if (preamble) cnt_d = cnt_q + 8'd1;
            ab_d   = {^(G_A & window), ^(G_B & window)};
            vld_d  = keep;
            last_d = last_sym;
        end else if (slot_free) begin
            ab_d   = 2'b00;
            vld_d  = 2'b00;
            last_d = 1'b0;
        end

        if (frame_end) begin
            sr_d  = '0;
            cnt_d = '0;
        end

        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (accept) begin
                    if (state_q == ST_IDLE) rate_d = decode_rate(rate);
                    if (in_last) begin
`ifdef TAIL_FLUSH_EN
                        state_d = ST_TAIL;
                        tail_d  = '0;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_TAIL: begin
                if (tail_adv) begin
                    tail_d = tail_q + 4'd1;
                    if (tail_done) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rate_q   <= R12;
            sr_q     <= '0;
            cnt_q    <= '0;
            tail_q   <= '0;
            ab_q     <= 2'b00;
            vld_q    <= 2'b00;
            last_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rate_q   <= rate_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            tail_q   <= tail_d;
            ab_q     <= ab_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign out_ab    = ab_q;
    assign out_valid = vld_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_conv_encoder_punct_param.sv
// Bench for conv_encoder_punct_param: two instances (preamble 24 and preamble 0)
// share stimulus; consumed symbols are compared against a frame-level reference model.
module tb_conv_encoder_punct_param;

    localparam int         K    = 7;
    localparam logic [6:0] GA0  = 7'b1101101;
    localparam logic [6:0] GB0  = 7'b1001111;
    localparam logic [6:0] GA1  = 7'b1011011;
    localparam logic [6:0] GB1  = 7'b1111001;
    localparam int         PRE0 = 24;
    localparam int         PRE1 = 0;
`ifdef TAIL_FLUSH_EN
    localparam int         TAIL = K - 1;
`else
    localparam int         TAIL = 0;
`endif

    typedef struct packed {
        logic [1:0] ab;
        logic [1:0] keep;
        logic       last;
    } sym_t;

    typedef struct {
        logic       in_bit;
        logic [1:0] ab;
        logic [1:0] valid;
    } vec_t;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [3:0] rate = 4'b1101;
    logic       in_ready_a, out_last_a, in_ready_b, out_last_b;
    logic [1:0] out_ab_a, out_valid_a, out_ab_b, out_valid_b;

    sym_t exp_a[$];
    sym_t exp_b[$];
    bit   frame_bits[$];
    int   checks = 0;
    int   errors = 0;
    int   kept_b = 0;

    always #5 Clk = ~Clk;

    conv_encoder_punct_param #(.K(K), .G_A(GA0), .G_B(GB0), .PREAMBLE_LEN(PRE0)) dut_a (
        .Clk(Clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_a), .rate(rate), .out_ab(out_ab_a), .out_valid(out_valid_a),
        .out_last(out_last_a), .out_ready(out_ready)
    );

    conv_encoder_punct_param #(.K(K), .G_A(GA1), .G_B(GB1), .PREAMBLE_LEN(PRE1)) dut_b (
        .Clk(Clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_b), .rate(rate), .out_ab(out_ab_b), .out_valid(out_valid_b),
        .out_last(out_last_b), .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Keep mask for the idx-th symbol after the preamble.
    function automatic logic [1:0] keep_of(input logic [3:0] code, input int idx);
        case (code)
            4'b0001: return (idx % 2 == 0) ? 2'b11 : 2'b10;
            4'b1111, 4'b0111, 4'b1011, 4'b0011: begin
                case (idx % 3)
                    0:       return 2'b11;
                    1:       return 2'b10;
                    default: return 2'b01;
                endcase
            end
            4'b0010: begin
                case (idx % 5)
                    0:       return 2'b11;
                    1, 3:    return 2'b10;
                    default: return 2'b01;
                endcase
            end
            default: return 2'b11;
        endcase
    endfunction

    // Symbol j of a frame: a tap sees input bit j-i, zero outside the frame.
    function automatic sym_t model_sym(input logic [6:0] ga, input logic [6:0] gb, input int pre,
                                       input logic [3:0] code, input int j, input int n);
        sym_t s;
        logic a, b, v;
        a = 1'b0;
        b = 1'b0;
        for (int i = 0; i < K; i++) begin
            v = (j - i >= 0 && j - i < n) ? frame_bits[j-i] : 1'b0;
            a ^= ga[i] & v;
            b ^= gb[i] & v;
        end
        s.ab   = {a, b};
        s.keep = (j < pre) ? 2'b11 : keep_of(code, j - pre);
        s.last = (j == n + TAIL - 1);
        return s;
    endfunction

    task automatic push_frame(input logic [3:0] code);
        int n;
        n = frame_bits.size();
        for (int j = 0; j < n + TAIL; j++) begin
            exp_a.push_back(model_sym(GA0, GB0, PRE0, code, j, n));
            exp_b.push_back(model_sym(GA1, GB1, PRE1, code, j, n));
        end
    endtask

    // A symbol presented at a falling edge with out_ready high is consumed at the next rising edge.
    always @(negedge Clk) begin
        if (reset && out_ready) begin
            if (out_valid_a != 2'b00) begin
                if (exp_a.size() == 0) check("a_extra_symbol", {30'd0, out_valid_a}, 32'd0);
                else check("a_symbol", {out_ab_a, out_valid_a, out_last_a}, exp_a.pop_front());
            end
            if (out_valid_b != 2'b00) begin
                kept_b += $countones(out_valid_b);
                if (exp_b.size() == 0) check("b_extra_symbol", {30'd0, out_valid_b}, 32'd0);
                else check("b_symbol", {out_ab_b, out_valid_b, out_last_b}, exp_b.pop_front());
            end
        end
    end

    // Called and returns one time unit after a rising edge.
    task automatic send_bit(input logic b, input logic last, input bit rnd);
        bit got;
        got = 1'b0;
        in_bit   = b;
        in_valid = 1'b1;
        in_last  = last;
        for (int t = 0; t < 300; t++) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge Clk);
            if (in_ready_a) begin
                got = 1'b1;
                break;
            end
            @(posedge Clk);
            #1;
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        else begin
            @(posedge Clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic fill_random(input int n);
        frame_bits.delete();
        for (int i = 0; i < n; i++) frame_bits.push_back(bit'($urandom_range(0, 1)));
    endtask

    task automatic run_frame(input logic [3:0] code, input bit rnd);
        int n;
        n = frame_bits.size();
        push_frame(code);
        rate = code;
        for (int i = 0; i < n; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge Clk);
                    #1;
                end
            end
            send_bit(frame_bits[i], i == n - 1, rnd);
            if (i == 0 && rnd) rate = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (exp_a.size() == 0 && exp_b.size() == 0) break;
            @(posedge Clk);
            #1;
        end
        check("drain_a_left", exp_a.size(), 32'd0);
        check("drain_b_left", exp_b.size(), 32'd0);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t     tbl [7];
        logic [1:0] snap_ab, snap_v;
        int       kept_start;

        tbl[0] = '{1'b1, 2'b11, 2'b11};
        tbl[1] = '{1'b0, 2'b01, 2'b11};
        tbl[2] = '{1'b0, 2'b11, 2'b11};
        tbl[3] = '{1'b0, 2'b11, 2'b11};
        tbl[4] = '{1'b0, 2'b00, 2'b11};
        tbl[5] = '{1'b0, 2'b10, 2'b11};
        tbl[6] = '{1'b0, 2'b11, 2'b11};

        #2 reset = 1'b0;
        #1;
        check("reset_out_valid", {30'd0, out_valid_a}, 32'd0);
        check("reset_out_ab", {30'd0, out_ab_a}, 32'd0);
        check("reset_out_last", {31'd0, out_last_a}, 32'd0);
        #20 reset = 1'b1;
        @(posedge Clk);
        #1;
        check("ready_after_reset", {31'd0, in_ready_a}, 32'd1);

        // Impulse response at rate 1/2.
        frame_bits.delete();
        for (int i = 0; i < 7; i++) frame_bits.push_back(tbl[i].in_bit);
        push_frame(4'b1101);
        rate = 4'b1101;
        for (int i = 0; i < 7; i++) begin
            send_bit(tbl[i].in_bit, i == 6, 1'b0);
            check("impulse_ab", {30'd0, out_ab_a}, {30'd0, tbl[i].ab});
            check("impulse_valid", {30'd0, out_valid_a}, {30'd0, tbl[i].valid});
        end
        drain();

        // Rate 3/4 past a 24-bit preamble.
        fill_random(30);
        run_frame(4'b0011, 1'b0);
        drain();

        // Rate 5/6 with no preamble on the second instance.
        kept_start = kept_b;
        fill_random(10);
        run_frame(4'b0010, 1'b0);
        drain();
`ifdef TAIL_FLUSH_EN
        check("kept_bits_56", kept_b - kept_start, 32'd20);
`else
        check("kept_bits_56", kept_b - kept_start, 32'd12);
`endif

        // Output stall mid-frame.
        fill_random(12);
        push_frame(4'b1111);
        rate = 4'b1111;
        for (int i = 0; i < 5; i++) send_bit(frame_bits[i], 1'b0, 1'b0);
        out_ready = 1'b0;
        in_bit    = frame_bits[5];
        in_valid  = 1'b1;
        snap_ab   = out_ab_a;
        snap_v    = out_valid_a;
        repeat (3) begin
            @(negedge Clk);
            check("stall_in_ready", {31'd0, in_ready_a}, 32'd0);
            check("stall_out_ab", {30'd0, out_ab_a}, {30'd0, snap_ab});
            check("stall_out_valid", {30'd0, out_valid_a}, {30'd0, snap_v});
        end
        @(posedge Clk);
        #1;
        out_ready = 1'b1;
        for (int i = 5; i < 12; i++) send_bit(frame_bits[i], i == 11, 1'b0);
        drain();

`ifdef TAIL_FLUSH_EN
        // Tail flush timing on an 8-bit frame.
        fill_random(8);
        push_frame(4'b1101);
        rate = 4'b1101;
        for (int i = 0; i < 8; i++) send_bit(frame_bits[i], i == 7, 1'b0);
        for (int i = 0; i < K; i++) begin
            @(negedge Clk);
            check("tail_in_ready", {31'd0, in_ready_a}, {31'd0, (i == K - 1)});
            check("tail_out_last", {31'd0, out_last_a}, {31'd0, (i == K - 1)});
        end
        @(posedge Clk);
        #1;
        drain();
`endif

        // Asynchronous reset mid-frame, then the same frame from a clean start.
        fill_random(12);
        push_frame(4'b1111);
        rate = 4'b1111;
        for (int i = 0; i < 5; i++) send_bit(frame_bits[i], 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midrst_out_valid", {30'd0, out_valid_a}, 32'd0);
        check("midrst_out_last", {31'd0, out_last_a}, 32'd0);
        check("midrst_out_valid_b", {30'd0, out_valid_b}, 32'd0);
        exp_a.delete();
        exp_b.delete();
        #10 reset = 1'b1;
        @(posedge Clk);
        #1;
        run_frame(4'b1111, 1'b1);
        drain();

        // Randomised frames: lengths, rate codes, gaps, backpressure, mid-frame rate changes.
        for (int f = 0; f < 40; f++) begin
            fill_random($urandom_range(1, 40));
            run_frame(4'($urandom_range(0, 15)), 1'b1);
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
